// File: rtl/async_fifo_wr_adapter.sv
// async_fifo_wr_adapter: skid-buffered valid/ready front end driving the async FIFO write port
module async_fifo_wr_adapter #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    input  logic                  wfull,
    output logic                  winc,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [1:0]            occupancy,
    input  logic                  stall_clr,
    output logic [CNT_WIDTH-1:0]  stall_cnt
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
    state_t state, next_state;
    logic [DATA_WIDTH-1:0] tail;
    logic accept, pop;
    assign accept = s_valid & s_ready;
    assign pop = (state != EMPTY) & ~wfull;
    assign winc = pop;
    assign occupancy = state;
    always_comb
        next_state = state == EMPTY ? (accept ? ONE : EMPTY) :
                     state == ONE   ? (accept & ~pop ? TWO : ~accept & pop ? EMPTY : ONE) :
                                      (pop ? ONE : TWO);
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state     <= EMPTY;
            s_ready   <= 1'b0;
            wdata     <= '0;
            tail      <= '0;
            stall_cnt <= '0;
        end else begin
            state   <= next_state;
            s_ready <= next_state != TWO;
            if (accept && (state == EMPTY || pop))
                wdata <= s_data;
            else if (state == TWO && pop)
                wdata <= tail;
            if (accept && state == ONE && !pop)
                tail <= s_data;
            if (stall_clr)
                stall_cnt <= '0;
            else if (state != EMPTY && wfull && !(&stall_cnt))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_async_fifo_wr_adapter.sv
// tb_async_fifo_wr_adapter: directed and random scoreboard bench for the write-side adapter
module tb_async_fifo_wr_adapter;
    localparam int DW = 8;
    localparam int CW = 4;
    logic          wclk = 1'b0;
    logic          wrst_n, s_valid, wfull, stall_clr;
    logic [DW-1:0] s_data;
    logic          s_ready, winc;
    logic [DW-1:0] wdata;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_cnt;
    logic [DW-1:0] q[$];
    logic          acc;
    int            n_cmp, n_err, n_acc, n_wr;
    async_fifo_wr_adapter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .wfull(wfull), .winc(winc), .wdata(wdata),
        .occupancy(occupancy), .stall_clr(stall_clr), .stall_cnt(stall_cnt)
    );
    always #5 wclk = ~wclk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic cyc();
        logic [31:0] exp;
        @(negedge wclk);
        acc = wrst_n && s_valid && s_ready;
        if (acc) begin
            q.push_back(s_data);
            n_acc++;
        end
        if (winc) begin
            n_wr++;
            chk("no_overflow", {31'b0, wfull}, 32'd0);
            exp = q.size() != 0 ? {24'b0, q.pop_front()} : 32'hx;
            chk("sb_data", {24'b0, wdata}, exp);
        end
        @(posedge wclk);
        #1;
    endtask
    initial begin
        n_cmp = 0; n_err = 0; n_acc = 0; n_wr = 0; acc = 1'b0;
        wrst_n = 1'b0; s_valid = 1'b0; s_data = '0; wfull = 1'b0; stall_clr = 1'b0;
        repeat (3) cyc();
        chk("rst_s_ready", {31'b0, s_ready}, 32'd0);
        chk("rst_winc", {31'b0, winc}, 32'd0);
        chk("rst_occ", {30'b0, occupancy}, 32'd0);
        chk("rst_stall", {28'b0, stall_cnt}, 32'd0);
        chk("rst_wdata", {24'b0, wdata}, 32'd0);
        wrst_n = 1'b1;
        chk("rel_s_ready_low", {31'b0, s_ready}, 32'd0);
        cyc();
        chk("rel_s_ready_high", {31'b0, s_ready}, 32'd1);
        // streaming: word i accepted at edge i is written in the following cycle
        for (int i = 0; i < 16; i++) begin
            s_valid = 1'b1;
            s_data = DW'(i);
            chk("stream_winc", {31'b0, winc}, i != 0 ? 32'd1 : 32'd0);
            if (i != 0) chk("stream_wdata", {24'b0, wdata}, 32'(i - 1));
            chk("stream_ready", {31'b0, s_ready}, 32'd1);
            cyc();
        end
        s_valid = 1'b0;
        chk("stream_last_winc", {31'b0, winc}, 32'd1);
        chk("stream_last_wdata", {24'b0, wdata}, 32'h0f);
        cyc();
        chk("stream_done", {31'b0, winc}, 32'd0);
        wfull = 1'b1; s_valid = 1'b1; s_data = 8'hA1;
        cyc();
        s_data = 8'hA2;
        cyc();
        s_valid = 1'b0;
        chk("bp_occ", {30'b0, occupancy}, 32'd2);
        chk("bp_ready", {31'b0, s_ready}, 32'd0);
        chk("bp_winc", {31'b0, winc}, 32'd0);
        chk("bp_stall", {28'b0, stall_cnt}, 32'd1);
        wfull = 1'b0;
        #1;
        chk("bp_w1", {31'b0, winc}, 32'd1);
        chk("bp_d1", {24'b0, wdata}, 32'hA1);
        cyc();
        chk("bp_w2", {31'b0, winc}, 32'd1);
        chk("bp_d2", {24'b0, wdata}, 32'hA2);
        chk("bp_ready_back", {31'b0, s_ready}, 32'd1);
        cyc();
        chk("bp_drained", {30'b0, occupancy}, 32'd0);
        s_valid = 1'b1; s_data = 8'hB1;
        cyc();
        s_data = 8'hB2;
        chk("sim_head", {24'b0, wdata}, 32'hB1);
        chk("sim_winc", {31'b0, winc}, 32'd1);
        cyc();
        s_valid = 1'b0;
        chk("sim_occ", {30'b0, occupancy}, 32'd1);
        chk("sim_wdata", {24'b0, wdata}, 32'hB2);
        cyc();
        chk("sim_drained", {30'b0, occupancy}, 32'd0);
        stall_clr = 1'b1;
        cyc();
        stall_clr = 1'b0;
        chk("stall_clr0", {28'b0, stall_cnt}, 32'd0);
        wfull = 1'b1; s_valid = 1'b1; s_data = 8'hC1;
        cyc();
        s_valid = 1'b0;
        repeat (3) cyc();
        chk("stall_3", {28'b0, stall_cnt}, 32'd3);
        repeat (17) cyc();
        chk("stall_sat", {28'b0, stall_cnt}, 32'd15);
        stall_clr = 1'b1;
        cyc();
        stall_clr = 1'b0;
        chk("stall_clr", {28'b0, stall_cnt}, 32'd0);
        cyc();
        chk("stall_after_clr", {28'b0, stall_cnt}, 32'd1);
        wfull = 1'b0;
        #1;
        chk("stall_drain_d", {24'b0, wdata}, 32'hC1);
        cyc();
        // reset while two words are buffered and a write is in progress
        wfull = 1'b1; s_valid = 1'b1; s_data = 8'hD1;
        cyc();
        s_data = 8'hD2;
        cyc();
        s_valid = 1'b0;
        chk("mid_occ", {30'b0, occupancy}, 32'd2);
        wfull = 1'b0;
        #1;
        chk("mid_winc_pre", {31'b0, winc}, 32'd1);
        wrst_n = 1'b0;
        q.delete();
        #1;
        chk("mid_winc", {31'b0, winc}, 32'd0);
        chk("mid_ready", {31'b0, s_ready}, 32'd0);
        chk("mid_occ0", {30'b0, occupancy}, 32'd0);
        chk("mid_stall", {28'b0, stall_cnt}, 32'd0);
        repeat (2) cyc();
        wrst_n = 1'b1;
        chk("mid_rel_low", {31'b0, s_ready}, 32'd0);
        cyc();
        chk("mid_rel_high", {31'b0, s_ready}, 32'd1);
        n_acc = 0; n_wr = 0; acc = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if (acc || !s_valid) begin
                s_valid = $urandom_range(0, 3) != 0;
                s_data = DW'($urandom);
            end
            wfull = $urandom_range(0, 2) == 0;
            cyc();
        end
        s_valid = 1'b0; wfull = 1'b0;
        repeat (4) cyc();
        chk("rnd_left", q.size(), 32'd0);
        chk("rnd_count", n_wr, n_acc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
